// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and the state type for the LCD text buffer.
// Optional feature macro: LCD_TBUF_SCROLL_EN adds the SCROLL state.
package lcd_pkg;

    localparam int unsigned LCD_COLS  = 16;
    localparam int unsigned LCD_DEPTH = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 8;

    localparam logic [DATA_W-1:0] CHR_BS    = 8'h08;
    localparam logic [DATA_W-1:0] CHR_LF    = 8'h0A;
    localparam logic [DATA_W-1:0] CHR_FF    = 8'h0C;
    localparam logic [DATA_W-1:0] CHR_CR    = 8'h0D;
    localparam logic [DATA_W-1:0] CHR_SPACE = 8'h20;
    localparam logic [DATA_W-1:0] FILL_CHAR = CHR_SPACE;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
`ifdef LCD_TBUF_SCROLL_EN
        ST_IDLE   = 2'd1,
        ST_SCROLL = 2'd2
`else
        ST_IDLE   = 2'd1
`endif
    } state_e;

    // True for bytes that are written to the screen (0x20..0x7E).
    function automatic logic is_printable(input logic [DATA_W-1:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// lcd_char_ram: 32x8 screen register file.
// Ports: clk; two async read ports (rd_a_* for the LCD, rd_b_* for the
// scroll source); two synchronous write ports (wr_a_*, wr_b_*). Callers
// guarantee the two write addresses never collide.
module lcd_char_ram
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data_c,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data_c,
    input  logic              wr_a_en,
    input  logic [ADDR_W-1:0] wr_a_addr,
    input  logic [DATA_W-1:0] wr_a_data,
    input  logic              wr_b_en,
    input  logic [ADDR_W-1:0] wr_b_addr,
    input  logic [DATA_W-1:0] wr_b_data
);

    logic [DATA_W-1:0] mem_q [LCD_DEPTH];

    // Storage is intentionally not reset; CLEAR overwrites it.
    always_ff @(posedge clk) begin
        if (wr_a_en) mem_q[wr_a_addr] <= wr_a_data;
        if (wr_b_en) mem_q[wr_b_addr] <= wr_b_data;
    end

    assign rd_a_data_c = mem_q[rd_a_addr];
    assign rd_b_data_c = mem_q[rd_b_addr];

endmodule

// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: text-terminal front end holding the 16x2 screen image.
// Ports: clk, rst_n (async active-low); in_data/in_valid/in_ready byte
// stream; mem_addr/mem_bus LCD read port (combinational); cursor (next
// write position); busy (= ~in_ready, high during clear/scroll).
// Optional feature macro: LCD_TBUF_SCROLL_EN (bottom-row overflow scrolls).
module lcd_text_buffer
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_bus,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic              ready_q, ready_d;

    logic              wr_a_en, wr_b_en;
    logic [ADDR_W-1:0] wr_a_addr, wr_b_addr, scr_src_addr;
    logic [DATA_W-1:0] wr_a_data, wr_b_data, scr_src_data;
    logic              accept;

    assign accept       = in_valid && ready_q;
    assign scr_src_addr = {1'b1, idx_q[3:0]};

    lcd_char_ram u_ram (
        .clk         (clk),
        .rd_a_addr   (mem_addr),
        .rd_a_data_c (mem_bus),
        .rd_b_addr   (scr_src_addr),
        .rd_b_data_c (scr_src_data),
        .wr_a_en     (wr_a_en),
        .wr_a_addr   (wr_a_addr),
        .wr_a_data   (wr_a_data),
        .wr_b_en     (wr_b_en),
        .wr_b_addr   (wr_b_addr),
        .wr_b_data   (wr_b_data)
    );

`ifndef LCD_TBUF_SCROLL_EN
    logic unused_scr;
    assign unused_scr = ^scr_src_data;
`endif

    // State register, sweep index, cursor and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_CLEAR;
            idx_q    <= '0;
            cursor_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cursor_q <= cursor_d;
            ready_q  <= ready_d;
        end
    end

    // Next-state, cursor update and RAM write selection.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cursor_d  = cursor_q;
        wr_a_en   = 1'b0;
        wr_a_addr = idx_q;
        wr_a_data = FILL_CHAR;
        wr_b_en   = 1'b0;
        wr_b_addr = {1'b1, idx_q[3:0]};
        wr_b_data = FILL_CHAR;

        case (state_q)
            ST_CLEAR: begin
                wr_a_en = 1'b1;
                if (idx_q == ADDR_W'(LCD_DEPTH - 1)) begin
                    state_d  = ST_IDLE;
                    idx_d    = '0;
                    cursor_d = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end

            ST_IDLE: begin
                if (accept) begin
                    if (is_printable(in_data)) begin
                        wr_a_en   = 1'b1;
                        wr_a_addr = cursor_q;
                        wr_a_data = in_data;
                        if (cursor_q == ADDR_W'(LCD_DEPTH - 1)) begin
`ifdef LCD_TBUF_SCROLL_EN
                            state_d = ST_SCROLL;
                            idx_d   = '0;
`else
                            cursor_d = '0;
`endif
                        end else begin
                            cursor_d = cursor_q + ADDR_W'(1);
                        end
                    end else begin
                        case (in_data)
                            CHR_CR: cursor_d = {cursor_q[4], 4'b0000};
                            CHR_LF: begin
                                if (!cursor_q[4]) begin
                                    cursor_d = cursor_q + ADDR_W'(LCD_COLS);
                                end else begin
`ifdef LCD_TBUF_SCROLL_EN
                                    state_d = ST_SCROLL;
                                    idx_d   = '0;
`else
                                    cursor_d = cursor_q - ADDR_W'(LCD_COLS);
`endif
                                end
                            end
                            CHR_BS: begin
                                if (cursor_q != '0) begin
                                    cursor_d  = cursor_q - ADDR_W'(1);
                                    wr_a_en   = 1'b1;
                                    wr_a_addr = cursor_q - ADDR_W'(1);
                                end
                            end
                            CHR_FF: begin
                                state_d = ST_CLEAR;
                                idx_d   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

`ifdef LCD_TBUF_SCROLL_EN
            // Row 1 moves up into row 0 while row 1 is blanked, one column per cycle.
            ST_SCROLL: begin
                wr_a_en   = 1'b1;
                wr_a_addr = {1'b0, idx_q[3:0]};
                wr_a_data = scr_src_data;
                wr_b_en   = 1'b1;
                if (idx_q[3:0] == 4'hF) begin
                    state_d  = ST_IDLE;
                    idx_d    = '0;
                    cursor_d = ADDR_W'(LCD_COLS);
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
`endif

            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    assign in_ready = ready_q;
    assign busy     = ~ready_q;
    assign cursor   = cursor_q;

endmodule
